// File: rtl/cpu_run_ctrl_if.sv
// Command/status bundle between the touchscreen/display logic and cpu_run_ctrl.
//   master side (display/touch logic + CPU): drives cmd_valid, cmd_op, cmd_arg, cpu_pc;
//     observes cmd_ready, clk_en, busy, done, stop_reason, cycle_count.
//   slave side (cpu_run_ctrl): the reverse.
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        cmd_ready;
    logic [31:0] cpu_pc;
    logic        clk_en;
    logic        busy;
    logic        done;
    logic [1:0]  stop_reason;
    logic [31:0] cycle_count;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cpu_pc,
        input  cmd_ready, clk_en, busy, done, stop_reason, cycle_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cpu_pc,
        output cmd_ready, clk_en, busy, done, stop_reason, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step controller producing the gated-clock enable for the single-cycle CPU.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   btn_step : raw push-button, asynchronous to clk
//   bus      : command inputs (STEP/RUN_N/RUN_BP/HALT), cpu_pc feedback and
//              registered status (cmd_ready, clk_en, busy, done, stop_reason, cycle_count)
module cpu_run_ctrl #(
    parameter logic [31:0] TIMEOUT     = 32'd1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_step,
    cpu_run_ctrl_if.slave bus
);

    localparam int unsigned W = 32;

    localparam logic [1:0] OP_STEP   = 2'd0;
    localparam logic [1:0] OP_RUN_N  = 2'd1;
    localparam logic [1:0] OP_RUN_BP = 2'd2;
    localparam logic [1:0] OP_HALT   = 2'd3;

    localparam logic [1:0] SR_STEP  = 2'd0;
    localparam logic [1:0] SR_COUNT = 2'd1;
    localparam logic [1:0] SR_BP    = 2'd2;
    localparam logic [1:0] SR_HALT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN_N  = 2'd1,
        S_BP_EN  = 2'd2,
        S_BP_CHK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     remaining_q, remaining_d;
    logic [W-1:0]     run_cnt_q, run_cnt_d;
    logic [W-1:0]     bp_q, bp_d;
    logic [W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             done_q, done_d;
    logic [1:0]       stop_q, stop_d;
    logic             busy_q;
    logic             ready_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_prev_q;
    logic                   btn_edge;
    logic                   halt_req;

    // Button synchronizer plus one extra flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_step};
            btn_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign btn_edge = sync_q[SYNC_STAGES-1] & ~btn_prev_q;
    assign halt_req = bus.cmd_valid && (bus.cmd_op == OP_HALT);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            run_cnt_q   <= '0;
            bp_q        <= '0;
            cycle_cnt_q <= '0;
            clk_en_q    <= 1'b0;
            done_q      <= 1'b0;
            stop_q      <= SR_STEP;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            run_cnt_q   <= run_cnt_d;
            bp_q        <= bp_d;
            cycle_cnt_q <= cycle_cnt_d;
            clk_en_q    <= clk_en_d;
            done_q      <= done_d;
            stop_q      <= stop_d;
            busy_q      <= (state_d != S_IDLE);
            ready_q     <= (state_d == S_IDLE);
        end
    end

    // Next-state and next-output logic; clk_en_d is the enable for the coming cycle
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        run_cnt_d   = run_cnt_q;
        bp_d        = bp_q;
        clk_en_d    = 1'b0;
        done_d      = 1'b0;
        stop_d      = stop_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    // A command always takes precedence over a coincident button edge
                    unique case (bus.cmd_op)
                        OP_STEP: begin
                            clk_en_d = 1'b1;
                            done_d   = 1'b1;
                            stop_d   = SR_STEP;
                        end
                        OP_RUN_N: begin
                            if (bus.cmd_arg == '0) begin
                                done_d = 1'b1;
                                stop_d = SR_COUNT;
                            end else begin
                                remaining_d = bus.cmd_arg;
                                clk_en_d    = 1'b1;
                                state_d     = S_RUN_N;
                            end
                        end
                        OP_RUN_BP: begin
                            bp_d      = bus.cmd_arg;
                            run_cnt_d = '0;
                            clk_en_d  = 1'b1;
                            state_d   = S_BP_EN;
                        end
                        default: ;
                    endcase
                end else if (btn_edge) begin
                    clk_en_d = 1'b1;
                    done_d   = 1'b1;
                    stop_d   = SR_STEP;
                end
            end

            S_RUN_N: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    stop_d  = SR_HALT;
                end else begin
                    remaining_d = remaining_q - W'(1);
                    if (remaining_q == W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        stop_d  = SR_COUNT;
                    end else begin
                        clk_en_d = 1'b1;
                    end
                end
            end

            S_BP_EN: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    stop_d  = SR_HALT;
                end else begin
                    run_cnt_d = run_cnt_q + W'(1);
                    state_d   = S_BP_CHK;
                end
            end

            S_BP_CHK: begin
                // cpu_pc reflects the CPU edge closed by the preceding BP_EN cycle
                if (halt_req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    stop_d  = SR_HALT;
                end else if (bus.cpu_pc == bp_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    stop_d  = SR_BP;
                end else if (run_cnt_q == TIMEOUT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    stop_d  = SR_HALT;
                end else begin
                    clk_en_d = 1'b1;
                    state_d  = S_BP_EN;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Counter advances together with the enable it counts
        cycle_cnt_d = cycle_cnt_q + W'(clk_en_d);
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.clk_en      = clk_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stop_reason = stop_q;
    assign bus.cycle_count = cycle_cnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller for the single-cycle CPU's gated clock. It produces the clock-enable that drives the CPU clock buffer (BUFGCE CE input). It supports the following modes:
- single-step from the board push-button
- run-N-cycles, run-to-breakpoint and halt, all from touchscreen commands
It reports status back to the display logic: busy, stop reason and a cycle counter.

Parameters:
TIMEOUT, 32'd1000000, maximum CPU cycles in one run-to-breakpoint before forced stop
SYNC_STAGES, 2, synchronizer flops on btn_step (minimum 2)

Ports:
clk  in  1  system clock (10 MHz)
reset  in  1  asynchronous, active-high reset
btn_step  in  1  raw push-button, active-high, asynchronous to clk
cmd_valid  in  1  command strobe from touchscreen input logic
cmd_op  in  2  0=STEP, 1=RUN_N, 2=RUN_BP, 3=HALT
cmd_arg  in  32  N for RUN_N; breakpoint PC for RUN_BP; ignored otherwise
cmd_ready  out  1  high when a non-HALT command is accepted (state IDLE)
cpu_pc  in  32  current CPU PC
clk_en  out  1  CPU clock enable; each high cycle = exactly one CPU cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a step/run finishes
stop_reason  out  2  0=step, 1=count reached, 2=breakpoint hit, 3=halt/timeout; held until next done
cycle_count  out  32  total clk_en pulses since reset

Behaviour:
- Reset (async, high): state=IDLE, clk_en=0, done=0, stop_reason=0, cycle_count=0, all counters and synchronizer flops 0. Deasserting reset alone causes no clk_en pulse.
- All outputs are registered. clk_en, done and busy change only on clk rising edge.

States: IDLE, RUN_N, BP_EN, BP_CHK.

IDLE:
- cmd_ready=1.
- STEP command, or a synchronized rising edge of btn_step: clk_en=1 for exactly one cycle, with done and stop_reason=0 in the same cycle. State stays IDLE.
- RUN_N with N=0: done pulse next cycle, stop_reason=1, no clk_en.
- RUN_N with N>0: load remaining=N, go to RUN_N.
- RUN_BP: latch bp=cmd_arg, clear run counter, go to BP_EN.
- HALT in IDLE: no-op, no done pulse.
- Button edge and cmd_valid in the same cycle: the command wins; the button edge is discarded.

RUN_N:
- clk_en=1 every cycle; remaining decrements each cycle.
- The cycle with remaining==1 is the last clk_en. The next cycle returns to IDLE with done=1, stop_reason=1.
- Exactly N pulses for any N in 1..2^32-1.

BP_EN:
- clk_en=1 for one cycle, run counter increments, go to BP_CHK.

BP_CHK:
- clk_en=0. cpu_pc has settled from the preceding enabled edge and is compared against bp.
- Equal: IDLE, done, stop_reason=2.
- Else if run counter==TIMEOUT: IDLE, done, stop_reason=3.
- Else: go back to BP_EN.
- At least one CPU cycle always executes, so RUN_BP issued while cpu_pc==bp steps off the breakpoint.
- Throughput is 1 CPU cycle per 2 clk.

HALT while busy:
- Accepted in any state regardless of cmd_ready.
- clk_en is forced 0 in the next cycle; state goes to IDLE with done and stop_reason=3.
- A clk_en already asserted in the HALT cycle completes and is counted.

Other rules:
- Non-HALT cmd_valid while busy: ignored, no side effects.
- btn_step edges while busy are discarded (not queued).
- Button edge detect uses the last two synchronized samples; holding the button yields exactly one step.
- cycle_count increments on every clk_en=1 cycle, wraps 2^32-1 -> 0.
- Reset mid-run: immediate abort; clk_en drops asynchronously; no done pulse.

Test Plan:
- Reset, then btn_step held high for 50 cycles -> exactly 1 clk_en pulse; cycle_count=1; done with stop_reason=0.
- RUN_N with arg=5 -> 5 consecutive clk_en cycles; busy high for 5 cycles; done next cycle, stop_reason=1, cycle_count=5. Then RUN_N with arg=0 -> done with no clk_en.
- RUN_BP with bp=0x0000_000C, cpu_pc model incrementing by 4 per enabled edge from 0 -> clk_en pattern 1,0 repeated 3 times; stop_reason=2; cycle_count +3. Reissue RUN_BP with the same bp while cpu_pc=0xC -> runs again (at least one cycle executed).
- RUN_N with arg=100, HALT at 10th clk_en cycle -> clk_en low next cycle; cycle_count=10; stop_reason=3. Non-HALT command sent during the run -> ignored.
- TIMEOUT=4, RUN_BP to an unreachable PC -> exactly 4 clk_en pulses, then stop_reason=3.
- reset asserted mid-RUN_N -> clk_en=0 and cycle_count=0 without waiting for clk; no done pulse; a btn_step edge in the same cycle as cmd_valid=STEP -> single pulse only.
